// File: rtl/damage_stun_manager.sv
// damage_stun_manager
// Converts edge-qualified hit/block frame-state codes from the hit checker
// into health deductions and frame-based stun countdowns, and runs the round
// flow IDLE -> FIGHT -> KO -> OVER.
// Optional feature macro: CHIP_DAMAGE_EN (blocked hits also remove 1 health).
module damage_stun_manager #(
    parameter logic [3:0] MAX_HEALTH       = 4'd3,
    parameter logic [3:0] HIT_DAMAGE       = 4'd1,
    parameter logic [5:0] HITSTUN_FRAMES   = 6'd30,
    parameter logic [5:0] BLOCKSTUN_FRAMES = 6'd15,
    parameter logic [7:0] KO_HOLD_FRAMES   = 8'd120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       round_start,
    input  logic [1:0] char1_frame_state,
    input  logic [1:0] char2_frame_state,
    output logic [3:0] char1_health,
    output logic [3:0] char2_health,
    output logic       char1_stun,
    output logic       char2_stun,
    output logic       char1_stun_block,
    output logic       char2_stun_block,
    output logic       round_active,
    output logic       ko_flag,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {S_IDLE, S_FIGHT, S_KO, S_OVER} state_t;

    state_t      state_q, state_d;
    logic [1:0]  prev1_q, prev1_d, prev2_q, prev2_d;
    logic [3:0]  h1_q, h1_d, h2_q, h2_d;
    logic [5:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic        blk1_q, blk1_d, blk2_q, blk2_d;
    logic        stun1_q, stun1_d, stun2_q, stun2_d;
    logic [7:0]  ko_cnt_q, ko_cnt_d;
    logic        active_q, active_d, ko_q, ko_d;
    logic [1:0]  winner_q, winner_d;

    logic        hit1, hit2, blkev1, blkev2, take1, take2, restart;

    // Health minus damage using a 5-bit intermediate; underflow clamps to 0.
    function automatic logic [3:0] sub_sat(input logic [3:0] h, input logic [3:0] d);
        logic [4:0] diff;
        diff = {1'b0, h} - {1'b0, d};
        return diff[4] ? 4'd0 : diff[3:0];
    endfunction

    // Edge-qualified events: previous sample must be "no hit" (11 counts as 00).
    assign hit1    = (char1_frame_state == 2'b01) && (prev1_q == 2'b00);
    assign blkev1  = (char1_frame_state == 2'b10) && (prev1_q == 2'b00);
    assign hit2    = (char2_frame_state == 2'b01) && (prev2_q == 2'b00);
    assign blkev2  = (char2_frame_state == 2'b10) && (prev2_q == 2'b00);
    // Events only land in FIGHT on a character that is not already stunned.
    assign take1   = (state_q == S_FIGHT) && (cnt1_q == 6'd0);
    assign take2   = (state_q == S_FIGHT) && (cnt2_q == 6'd0);
    assign restart = ((state_q == S_IDLE) || (state_q == S_OVER)) && round_start;

    // Next-state computation for round flow, health and stun countdowns.
    always_comb begin
        state_d  = state_q;
        h1_d     = h1_q;
        h2_d     = h2_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        blk1_d   = blk1_q;
        blk2_d   = blk2_q;
        ko_cnt_d = ko_cnt_q;
        active_d = active_q;
        ko_d     = ko_q;
        winner_d = winner_q;
        prev1_d  = (char1_frame_state == 2'b11) ? 2'b00 : char1_frame_state;
        prev2_d  = (char2_frame_state == 2'b11) ? 2'b00 : char2_frame_state;

        // Stun loads take priority over a coincident frame_tick decrement.
        if (restart) begin
            cnt1_d = 6'd0;
            blk1_d = 1'b0;
        end else if (take1 && hit1) begin
            cnt1_d = HITSTUN_FRAMES;
            blk1_d = 1'b0;
        end else if (take1 && blkev1) begin
            cnt1_d = BLOCKSTUN_FRAMES;
            blk1_d = 1'b1;
        end else if (frame_tick && (cnt1_q != 6'd0)) begin
            cnt1_d = cnt1_q - 6'd1;
            if (cnt1_q == 6'd1) blk1_d = 1'b0;
        end

        if (restart) begin
            cnt2_d = 6'd0;
            blk2_d = 1'b0;
        end else if (take2 && hit2) begin
            cnt2_d = HITSTUN_FRAMES;
            blk2_d = 1'b0;
        end else if (take2 && blkev2) begin
            cnt2_d = BLOCKSTUN_FRAMES;
            blk2_d = 1'b1;
        end else if (frame_tick && (cnt2_q != 6'd0)) begin
            cnt2_d = cnt2_q - 6'd1;
            if (cnt2_q == 6'd1) blk2_d = 1'b0;
        end

        if (take1 && hit1) h1_d = sub_sat(h1_q, HIT_DAMAGE);
`ifdef CHIP_DAMAGE_EN
        else if (take1 && blkev1) h1_d = sub_sat(h1_q, 4'd1);
`endif
        if (take2 && hit2) h2_d = sub_sat(h2_q, HIT_DAMAGE);
`ifdef CHIP_DAMAGE_EN
        else if (take2 && blkev2) h2_d = sub_sat(h2_q, 4'd1);
`endif

        case (state_q)
            S_IDLE, S_OVER: begin
                if (round_start) begin
                    h1_d     = MAX_HEALTH;
                    h2_d     = MAX_HEALTH;
                    winner_d = 2'b00;
                    ko_d     = 1'b0;
                    active_d = 1'b1;
                    state_d  = S_FIGHT;
                end
            end
            S_FIGHT: begin
                if ((h1_d == 4'd0) || (h2_d == 4'd0)) begin
                    winner_d = {h1_d == 4'd0, h2_d == 4'd0};
                    ko_cnt_d = KO_HOLD_FRAMES;
                    ko_d     = 1'b1;
                    active_d = 1'b0;
                    state_d  = S_KO;
                end
            end
            S_KO: begin
                if (ko_cnt_q == 8'd0) begin
                    state_d = S_OVER;
                end else if (frame_tick) begin
                    ko_cnt_d = ko_cnt_q - 8'd1;
                    if (ko_cnt_q == 8'd1) state_d = S_OVER;
                end
            end
            default: state_d = S_IDLE;
        endcase

        stun1_d = (cnt1_d != 6'd0);
        stun2_d = (cnt2_d != 6'd0);
    end

    // State register; reset returns everything to the idle, zero-health state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            prev1_q  <= 2'b00;
            prev2_q  <= 2'b00;
            h1_q     <= 4'd0;
            h2_q     <= 4'd0;
            cnt1_q   <= 6'd0;
            cnt2_q   <= 6'd0;
            blk1_q   <= 1'b0;
            blk2_q   <= 1'b0;
            stun1_q  <= 1'b0;
            stun2_q  <= 1'b0;
            ko_cnt_q <= 8'd0;
            active_q <= 1'b0;
            ko_q     <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            prev1_q  <= prev1_d;
            prev2_q  <= prev2_d;
            h1_q     <= h1_d;
            h2_q     <= h2_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            blk1_q   <= blk1_d;
            blk2_q   <= blk2_d;
            stun1_q  <= stun1_d;
            stun2_q  <= stun2_d;
            ko_cnt_q <= ko_cnt_d;
            active_q <= active_d;
            ko_q     <= ko_d;
            winner_q <= winner_d;
        end
    end

    assign char1_health     = h1_q;
    assign char2_health     = h2_q;
    assign char1_stun       = stun1_q;
    assign char2_stun       = stun2_q;
    assign char1_stun_block = blk1_q;
    assign char2_stun_block = blk2_q;
    assign round_active     = active_q;
    assign ko_flag          = ko_q;
    assign winner           = winner_q;

endmodule
